spi_slave: RTL and testbench

//  SPI Mode 0 responder (CPOL=0, CPHA=0), MSB first, 8-bit frames, for use with the comproc CPU.

---
 rtl/spi_pkg.sv | 7 +
 rtl/spi_sync.sv | 29 ++
 rtl/spi_slave.sv | 130 +++++++++++++
 tb/tb_spi_slave.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants and state type for the SPI Mode 0 responder.
package spi_pkg;
  localparam int SPI_BITS = 8;
  localparam int CNT_W    = $clog2(SPI_BITS);

  typedef enum logic {IDLE, ACTIVE} spi_slv_state_t;
endpackage

// File: rtl/spi_sync.sv
// N-stage synchronizer; q, rise and fall are all registered and mutually aligned,
// appearing N+1 clk after the pin changes.
module spi_sync #(
  parameter int   N       = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [N-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {N{RST_VAL}};
      q     <= RST_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[N-2:0], d};
      q     <= chain[N-1];
      rise  <= chain[N-1] & ~q;
      fall  <= ~chain[N-1] & q;
    end
  end
endmodule

// File: rtl/spi_slave.sv
// SPI Mode 0 responder, MSB first, oversampled in clk (needs clk >= 8x sclk).
// Define SPI_SLAVE_OVERRUN_EN to enable the sticky overrun flag; otherwise overrun is tied 0.
module spi_slave
  import spi_pkg::*;
#(
  parameter logic [SPI_BITS-1:0] FILL        = 8'hFF,
  parameter int                  SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sclk,
  input  logic                cs_n,
  input  logic                mosi,
  output logic                miso,
  output logic                miso_oe,
  input  logic [SPI_BITS-1:0] tx_data,
  input  logic                tx_write,
  output logic                tx_ready,
  output logic [SPI_BITS-1:0] rx_data,
  output logic                rx_valid,
  input  logic                rx_ack,
  output logic                busy,
  output logic                overrun
);
  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic sync_unused;

  spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(sclk), .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .d(cs_n), .q(cs_s), .rise(cs_rise), .fall(cs_fall));
  spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(mosi), .q(mosi_s), .rise(mosi_rise), .fall(mosi_fall));

  assign sync_unused = ^{sclk_s, cs_s, mosi_rise, mosi_fall};

  spi_slv_state_t      state, state_next;
  logic [SPI_BITS-1:0] sreg, tx_buf, load_val, shifted;
  logic [CNT_W-1:0]    bit_cnt;
  logic                do_load, do_shift, do_miso, frame_end, byte_done, tx_accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // cs_n rise takes priority over any sclk edge seen in the same clk.
  always_comb begin
    state_next = state;
    do_load    = 1'b0;
    do_shift   = 1'b0;
    do_miso    = 1'b0;
    frame_end  = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_next = ACTIVE;
          do_load    = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_next = IDLE;
          frame_end  = 1'b1;
        end else begin
          do_shift = sclk_rise;
          do_miso  = sclk_fall;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign byte_done = do_shift && (bit_cnt == CNT_W'(SPI_BITS - 1));
  assign load_val  = tx_ready ? FILL : tx_buf;
  assign shifted   = {sreg[SPI_BITS-2:0], mosi_s};
  assign tx_accept = tx_write && tx_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg     <= '0;
      bit_cnt  <= '0;
      miso     <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_buf   <= '0;
      tx_ready <= 1'b1;
    end else begin
      if (do_load) begin
        sreg    <= load_val;
        miso    <= load_val[SPI_BITS-1];
        bit_cnt <= '0;
      end else if (do_shift) begin
        bit_cnt <= bit_cnt + 1'b1;
        sreg    <= byte_done ? load_val : shifted;
        if (byte_done) rx_data <= shifted;
      end else if (frame_end) begin
        bit_cnt <= '0;
      end

      if (do_miso) miso <= sreg[SPI_BITS-1];

      // A write coinciding with a load is stored for the next load; the load sees the old state.
      if (tx_accept) begin
        tx_buf   <= tx_data;
        tx_ready <= 1'b0;
      end else if (do_load || byte_done) begin
        tx_ready <= 1'b1;
      end

      if (byte_done)   rx_valid <= 1'b1;
      else if (rx_ack) rx_valid <= 1'b0;
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        overrun <= 1'b0;
    else if (rx_ack)                overrun <= 1'b0;
    else if (byte_done && rx_valid) overrun <= 1'b1;
  end
`else
  assign overrun = 1'b0;
`endif

  assign busy    = (state == ACTIVE);
  assign miso_oe = busy;
endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: SPI master model at clk/10 with an rx scoreboard.
module tb_spi_slave;
  logic       clk = 1'b0;
  logic       rst;
  logic       sclk, cs_n, mosi;
  logic       miso, miso_oe;
  logic [7:0] tx_data;
  logic       tx_write, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ack;
  logic       busy, overrun;

  logic       mon_ack = 1'b0;
  logic       man_ack = 1'b0;
  logic       auto_ack = 1'b1;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] rx_q[$];

  assign rx_ack = mon_ack | man_ack;

  always #5 clk = ~clk;

  spi_slave dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_write(tx_write),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
    .busy(busy), .overrun(overrun));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every presented rx byte is compared and acknowledged.
  initial begin
    forever begin
      @(negedge clk);
      mon_ack = 1'b0;
      if (auto_ack && rx_valid) begin
        checks++;
        if (rx_q.size() == 0) begin
          errors++;
          $display("FAIL rx_unexpected: got byte %0h, expected none", rx_data);
        end else begin
          logic [7:0] exp;
          exp = rx_q.pop_front();
          if (rx_data !== exp) begin
            errors++;
            $display("FAIL rx_data: got %0h, expected %0h", rx_data, exp);
          end
        end
        mon_ack = 1'b1;
      end
    end
  end

  task automatic wr(input logic [7:0] d);
    tx_data  = d;
    tx_write = 1'b1;
    @(negedge clk);
    tx_write = 1'b0;
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic end_frame();
    repeat (5) @(negedge clk);
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // Master samples miso just before each rising sclk edge.
  task automatic xfer(input logic [7:0] mo, input logic [7:0] exp, input string name);
    logic [7:0] got;
    got = '0;
    for (int i = 7; i >= 0; i--) begin
      mosi = mo[i];
      repeat (5) @(negedge clk);
      got[i] = miso;
      sclk = 1'b1;
      repeat (5) @(negedge clk);
      sclk = 1'b0;
    end
    check(name, got, exp);
  endtask

  task automatic partial(input logic [7:0] mo, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[7-i];
      repeat (5) @(negedge clk);
      sclk = 1'b1;
      repeat (5) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  initial begin
    logic exp_ovr;
`ifdef SPI_SLAVE_OVERRUN_EN
    exp_ovr = 1'b1;
`else
    exp_ovr = 1'b0;
`endif
    rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    tx_data = '0; tx_write = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_miso_oe", miso_oe, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 1: pending byte goes out; second write while full is dropped
    wr(8'h3C);
    check("t1_tx_ready_full", tx_ready, 0);
    wr(8'h99);
    cs_low();
    check("t1_busy", busy, 1);
    check("t1_miso_oe", miso_oe, 1);
    check("t1_tx_ready_empty", tx_ready, 1);
    rx_q.push_back(8'hA5);
    xfer(8'hA5, 8'h3C, "t1_miso");
    end_frame();
    check("t1_busy_after", busy, 0);

    // 2: nothing pending -> FILL
    cs_low();
    rx_q.push_back(8'h5A);
    xfer(8'h5A, 8'hFF, "t2_miso_fill");
    end_frame();

    // 3: back-to-back bytes with refill during byte 1
    cs_low();
    wr(8'h55);
    check("t3_tx_ready_full", tx_ready, 0);
    rx_q.push_back(8'h01);
    rx_q.push_back(8'h80);
    xfer(8'h01, 8'hFF, "t3_miso_b1");
    xfer(8'h80, 8'h55, "t3_miso_b2");
    check("t3_tx_ready", tx_ready, 1);
    end_frame();

    // 4: two bytes without ack
    auto_ack = 1'b0;
    cs_low();
    xfer(8'h12, 8'hFF, "t4_miso_b1");
    check("t4_rx_b1", rx_data, 8'h12);
    check("t4_ovr_b1", overrun, 0);
    xfer(8'h34, 8'hFF, "t4_miso_b2");
    check("t4_rx_b2", rx_data, 8'h34);
    check("t4_valid_b2", rx_valid, 1);
    check("t4_overrun", overrun, exp_ovr);
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    check("t4_valid_ack", rx_valid, 0);
    check("t4_ovr_ack", overrun, 0);
    end_frame();
    auto_ack = 1'b1;

    // 5: aborted partial byte, then an aligned frame
    cs_low();
    partial(8'hF0, 4);
    repeat (2) @(negedge clk);
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
    check("t5_no_valid", rx_valid, 0);
    check("t5_busy", busy, 0);
    wr(8'h96);
    cs_low();
    rx_q.push_back(8'hC3);
    xfer(8'hC3, 8'h96, "t5_miso");
    end_frame();

    // 6: reset mid-byte
    cs_low();
    wr(8'h77);
    check("t6_tx_ready_full", tx_ready, 0);
    partial(8'hAA, 3);
    check("t6_miso_pre", miso, 1);
    rst = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    #1;
    check("t6_miso", miso, 0);
    check("t6_miso_oe", miso_oe, 0);
    check("t6_rx_data", rx_data, 0);
    check("t6_rx_valid", rx_valid, 0);
    check("t6_tx_ready", tx_ready, 1);
    check("t6_busy", busy, 0);
    check("t6_overrun", overrun, 0);
    @(negedge clk);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    wr(8'h42);
    cs_low();
    rx_q.push_back(8'h81);
    xfer(8'h81, 8'h42, "t6_miso_after");
    end_frame();

    check("rx_q_drained", rx_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
